// File: rtl/ryg_phase_sched.sv
// Two-way traffic-light phase scheduler. Main road A is lamp bit 1 and side
// road B is lamp bit 0. A tick-timed FSM runs AG-AY-AR1-BG-BY-AR2. A latched
// side request can shorten AG, and a night mode flashes yellow on both roads.
module ryg_phase_sched #(
  parameter int CW       = 4,
  parameter int T_GRN_A  = 9,
  parameter int T_MIN_A  = 3,
  parameter int T_GRN_B  = 5,
  parameter int T_YEL    = 2,
  parameter int T_ALLRED = 1,
  parameter int T_FLASH  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       side_req,
  input  logic       night,
  output logic [1:0] r,
  output logic [1:0] y,
  output logic [1:0] g,
  output logic [2:0] phase,
  output logic       req_pend
);

  typedef enum logic [2:0] {
    S_AG  = 3'd0,
    S_AY  = 3'd1,
    S_AR1 = 3'd2,
    S_BG  = 3'd3,
    S_BY  = 3'd4,
    S_AR2 = 3'd5,
    S_FL  = 3'd6
  } state_t;

  // Each timed phase ends on the tick where the timer reaches its limit.
  localparam logic [CW-1:0] LIM_GA  = CW'(T_GRN_A - 1);
  localparam logic [CW-1:0] LIM_MA  = CW'(T_MIN_A - 1);
  localparam logic [CW-1:0] LIM_GB  = CW'(T_GRN_B - 1);
  localparam logic [CW-1:0] LIM_Y   = CW'(T_YEL - 1);
  localparam logic [CW-1:0] LIM_AR  = CW'(T_ALLRED - 1);
  localparam logic [CW-1:0] LIM_FL  = CW'(T_FLASH - 1);
  localparam logic [CW-1:0] TMR_MAX = {CW{1'b1}};

  state_t        state_q;
  logic [CW-1:0] timer_q;
  logic          fl_q;
  logic          req_q;

  logic          exit_c;
  logic          enter_bg;

  // Exit condition of the current phase, qualified by tick at the point of use.
  always_comb begin
    exit_c = 1'b0;
    case (state_q)
      S_AG:        exit_c = (timer_q == LIM_GA) || (req_q && (timer_q >= LIM_MA));
      S_AY, S_BY:  exit_c = (timer_q == LIM_Y);
      S_AR1, S_AR2: exit_c = (timer_q == LIM_AR);
      S_BG:        exit_c = (timer_q == LIM_GB);
      S_FL:        exit_c = !night;
      default:     exit_c = 1'b1;
    endcase
  end

  // Clearing on BG entry beats a same-cycle request; otherwise requests stick.
  assign enter_bg = tick && (state_q == S_AR1) && exit_c;

  // Phase FSM, phase timer, flash bit and request latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_AG;
      timer_q <= '0;
      fl_q    <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      req_q <= enter_bg ? 1'b0 : (req_q | side_req);
      if (tick) begin
        if (exit_c) begin
          timer_q <= '0;
          case (state_q)
            S_AG:    state_q <= S_AY;
            S_AY:    state_q <= S_AR1;
            S_AR1:   state_q <= S_BG;
            S_BG:    state_q <= S_BY;
            S_BY:    state_q <= S_AR2;
            S_AR2:   state_q <= night ? S_FL : S_AG;
            S_FL: begin
              state_q <= S_AR2;
              fl_q    <= 1'b0;
            end
            default: state_q <= S_AG;
          endcase
        end else if ((state_q == S_FL) && (timer_q == LIM_FL)) begin
          fl_q    <= ~fl_q;
          timer_q <= '0;
        end else if (timer_q != TMR_MAX) begin
          timer_q <= timer_q + 1'b1;
        end
      end
    end
  end

  // Lamp decode of the state register; all-red is the safe fallback.
  always_comb begin
    r = 2'b11;
    y = 2'b00;
    g = 2'b00;
    case (state_q)
      S_AG: begin r = 2'b01; g = 2'b10; end
      S_AY: begin r = 2'b01; y = 2'b10; end
      S_BG: begin r = 2'b10; g = 2'b01; end
      S_BY: begin r = 2'b10; y = 2'b01; end
      S_FL: begin r = 2'b00; y = fl_q ? 2'b11 : 2'b00; end
      default: ;
    endcase
  end

  assign phase    = state_q;
  assign req_pend = req_q;

endmodule

// File: tb/tb_ryg_phase_sched.sv
// Bench for ryg_phase_sched: directed vector table, two tick-spacing
// measurements, then random traffic against a phase/duration model.
module tb_ryg_phase_sched;

  localparam int T_GRN_A = 9, T_MIN_A = 3, T_GRN_B = 5, T_YEL = 2, T_ALLRED = 1, T_FLASH = 1;

  logic clk = 1'b0;
  logic rst = 1'b1, tick = 1'b0, side_req = 1'b0, night = 1'b0;
  logic [1:0] r, y, g;
  logic [2:0] phase;
  logic       req_pend;

  int checks = 0;
  int errors = 0;

  ryg_phase_sched dut (
    .clk(clk), .rst(rst), .tick(tick), .side_req(side_req), .night(night),
    .r(r), .y(y), .g(g), .phase(phase), .req_pend(req_pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: phase index + ticks elapsed ----------------
  int m_ph, m_n;
  bit m_fl, m_req, m_ok = 0;
  bit m_done, m_ebg;
  int m_nph;

  function automatic int dur(input int ph);
    case (ph)
      0: return T_GRN_A;
      1, 4: return T_YEL;
      2, 5: return T_ALLRED;
      3: return T_GRN_B;
      default: return T_FLASH;
    endcase
  endfunction

  function automatic logic [5:0] lamps(input int ph, input bit fl);
    case (ph)
      0: return 6'b01_00_10;
      1: return 6'b01_10_00;
      3: return 6'b10_00_01;
      4: return 6'b10_01_00;
      6: return fl ? 6'b00_11_00 : 6'b00_00_00;
      default: return 6'b11_00_00;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ph = 0; m_n = 0; m_fl = 0; m_req = 0; m_ok = 1;
    end else if (m_ok) begin
      m_done = 0;
      if (tick) begin
        if (m_ph == 6) m_done = !night;
        else if (m_ph == 0) m_done = (m_n + 1 == T_GRN_A) || (m_req && m_n + 1 >= T_MIN_A);
        else m_done = (m_n + 1 == dur(m_ph));
      end
      m_ebg = m_done && (m_ph == 2);
      m_req = m_ebg ? 1'b0 : (m_req | side_req);
      m_nph = m_ph;
      if (tick) begin
        if (m_done) begin
          if (m_ph == 5) m_nph = night ? 6 : 0;
          else if (m_ph == 6) begin m_nph = 5; m_fl = 0; end
          else m_nph = m_ph + 1;
          m_n = 0;
        end else if (m_ph == 6 && m_n + 1 == T_FLASH) begin
          m_fl = !m_fl; m_n = 0;
        end else if (m_n < 15) begin
          m_n = m_n + 1;
        end
      end
      m_ph = m_nph;
    end
  end

  // Every cycle: compare with the model and check lamp safety.
  always @(negedge clk) begin
    if (m_ok) begin
      chk("model_phase", phase, m_ph);
      chk("model_req", req_pend, m_req);
      chk("model_lamps", {r, y, g}, lamps(m_ph, m_fl));
      chk("inv_green", (g == 2'b11), 0);
      chk("inv_red", ((g | y) & r) != 2'b00, 0);
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    logic rst, tick, side, night;
    int   ncyc;
    int   ph;
    logic req;
    logic [1:0] r, y, g;
  } vec_t;

  vec_t tbl[64];
  int   nv = 0;

  task automatic addv(input logic rs, tk, sd, nt, input int n, ph, input logic rq,
                      input logic [1:0] er, ey, eg);
    tbl[nv] = '{rs, tk, sd, nt, n, ph, rq, er, ey, eg};
    nv++;
  endtask

  int c;

  initial begin
    //   rst tk sd nt  n  ph req  r      y      g
    addv(1, 0, 0, 0,  2, 0, 0, 2'b01, 2'b00, 2'b10);  // reset state
    addv(0, 1, 0, 0,  8, 0, 0, 2'b01, 2'b00, 2'b10);  // AG still on at timer 8
    addv(0, 1, 0, 0,  1, 1, 0, 2'b01, 2'b10, 2'b00);  // AY after 9 ticks
    addv(0, 0, 0, 0,  3, 1, 0, 2'b01, 2'b10, 2'b00);  // no tick: hold
    addv(0, 1, 0, 0,  2, 2, 0, 2'b11, 2'b00, 2'b00);  // AR1
    addv(0, 1, 0, 0,  1, 3, 0, 2'b10, 2'b00, 2'b01);  // BG
    addv(0, 1, 0, 0,  5, 4, 0, 2'b10, 2'b01, 2'b00);  // BY
    addv(0, 1, 0, 0,  2, 5, 0, 2'b11, 2'b00, 2'b00);  // AR2
    addv(0, 1, 0, 0,  1, 0, 0, 2'b01, 2'b00, 2'b10);  // back to AG
    addv(0, 1, 1, 0,  1, 0, 1, 2'b01, 2'b00, 2'b10);  // pulse at timer 0 latches
    addv(0, 1, 0, 0,  1, 0, 1, 2'b01, 2'b00, 2'b10);  // min green not yet met
    addv(0, 1, 0, 0,  1, 1, 1, 2'b01, 2'b10, 2'b00);  // AY after 3 ticks
    addv(0, 1, 0, 0,  2, 2, 1, 2'b11, 2'b00, 2'b00);
    addv(0, 1, 0, 0,  1, 3, 0, 2'b10, 2'b00, 2'b01);  // cleared on BG entry
    addv(0, 1, 0, 0,  5, 4, 0, 2'b10, 2'b01, 2'b00);
    addv(0, 1, 1, 0,  1, 4, 1, 2'b10, 2'b01, 2'b00);  // BY timer 1, re-armed
    addv(1, 0, 0, 0,  1, 0, 0, 2'b01, 2'b00, 2'b10);  // reset mid-BY -> AG
    addv(0, 1, 0, 0,  6, 0, 0, 2'b01, 2'b00, 2'b10);  // AG timer 6
    addv(0, 1, 1, 0,  1, 0, 1, 2'b01, 2'b00, 2'b10);  // late request
    addv(0, 1, 0, 0,  1, 1, 1, 2'b01, 2'b10, 2'b00);  // AY on next tick
    addv(1, 0, 0, 0,  1, 0, 0, 2'b01, 2'b00, 2'b10);
    addv(0, 1, 0, 0, 12, 3, 0, 2'b10, 2'b00, 2'b01);  // BG
    addv(0, 1, 0, 1,  5, 4, 0, 2'b10, 2'b01, 2'b00);  // night does not cut BG
    addv(0, 1, 0, 1,  2, 5, 0, 2'b11, 2'b00, 2'b00);  // nor BY
    addv(0, 1, 0, 1,  1, 6, 0, 2'b00, 2'b00, 2'b00);  // FL, fl=0
    addv(0, 1, 0, 1,  1, 6, 0, 2'b00, 2'b11, 2'b00);
    addv(0, 1, 0, 1,  1, 6, 0, 2'b00, 2'b00, 2'b00);
    addv(0, 1, 1, 1,  1, 6, 1, 2'b00, 2'b11, 2'b00);  // request held in FL
    addv(0, 1, 0, 0,  1, 5, 1, 2'b11, 2'b00, 2'b00);  // night off -> AR2
    addv(0, 1, 0, 0,  1, 0, 1, 2'b01, 2'b00, 2'b10);  // AG
    addv(0, 1, 0, 0,  3, 1, 1, 2'b01, 2'b10, 2'b00);  // served by shortened AG

    for (int i = 0; i < nv; i++) begin
      rst = tbl[i].rst; tick = tbl[i].tick; side_req = tbl[i].side; night = tbl[i].night;
      repeat (tbl[i].ncyc) @(posedge clk);
      #1;
      chk($sformatf("vec%0d_phase", i), phase, tbl[i].ph);
      chk($sformatf("vec%0d_req", i), req_pend, tbl[i].req);
      chk($sformatf("vec%0d_lamps", i), {r, y, g}, {tbl[i].r, tbl[i].y, tbl[i].g});
    end

    // Tick every 4th cycle: AG spans 36 clocks, AY 8.
    rst = 1; tick = 0; side_req = 0; night = 0;
    @(posedge clk); #1;
    rst = 0;
    c = 0;
    while (phase == 3'd0 && c < 100) begin
      tick = (c % 4 == 3);
      @(posedge clk); #1;
      c++;
    end
    chk("tick4_ag_len", c, 36);
    c = 0;
    while (phase == 3'd1 && c < 100) begin
      tick = (c % 4 == 3);
      @(posedge clk); #1;
      c++;
    end
    chk("tick4_ay_len", c, 8);

    // Random traffic; the model checker runs every cycle.
    for (int i = 0; i < 4000; i++) begin
      tick     = ($urandom_range(0, 99) < 60);
      side_req = ($urandom_range(0, 99) < 8);
      if ($urandom_range(0, 79) == 0) night = ~night;
      rst      = ($urandom_range(0, 599) == 0);
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
